voice_sched: RTL and testbench

VOICE_SCHED -- requirements
Module: voice_sched

---
 rtl/voice_sched.sv | 164 ++++++++++++++++
 tb/tb_voice_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/voice_sched.sv
// Time-multiplexed voice scheduler: allocates note-on requests to voices,
// releases them on note-off / all_off, and scans one voice slot per cycle
// producing registered accumulator enable/clear strobes and tuning words.
module voice_sched #(
    parameter int unsigned NUM_CHANNELS = 16,
    parameter int unsigned NUM_BITS     = 32,
    parameter int unsigned NOTE_BITS    = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    on_valid,
    output logic                    on_ready,
    input  logic [NOTE_BITS-1:0]    on_note,
    input  logic [NUM_BITS-1:0]     on_tw,
    input  logic                    off_valid,
    input  logic [NOTE_BITS-1:0]    off_note,
    input  logic                    all_off,
    output logic [NUM_CHANNELS-1:0] acc_en,
    output logic [NUM_CHANNELS-1:0] acc_clr,
    output logic [NUM_CHANNELS-1:0] curr_note,
    output logic [NUM_BITS-1:0]     tuning_word,
    output logic                    frame_start,
    output logic [NUM_CHANNELS-1:0] busy
);

    localparam int unsigned CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    // Per-voice state
    logic [NUM_CHANNELS-1:0] busy_q, busy_d;
    logic [NUM_CHANNELS-1:0] pend_q, pend_d;
    logic [NOTE_BITS-1:0]    note_q [NUM_CHANNELS];
    logic [NOTE_BITS-1:0]    note_d [NUM_CHANNELS];
    logic [NUM_BITS-1:0]     tw_q   [NUM_CHANNELS];
    logic [NUM_BITS-1:0]     tw_d   [NUM_CHANNELS];

    // Scan counter (next slot to present) and registered outputs
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0] curr_q, curr_d;
    logic [NUM_CHANNELS-1:0] en_q, en_d;
    logic [NUM_CHANNELS-1:0] clr_q, clr_d;
    logic [NUM_BITS-1:0]     twout_q, twout_d;
    logic                    fs_q, fs_d;

    // Request decode
    logic [NUM_CHANNELS-1:0] off_hit;
    logic [NUM_CHANNELS-1:0] on_hit;
    logic [NUM_CHANNELS-1:0] surv_hit;
    logic [NUM_CHANNELS-1:0] tgt_oh;
    logic [NUM_CHANNELS-1:0] slot_oh;
    logic [CW-1:0]           rt_idx, fr_idx, tgt_idx;
    logic                    rt_found, fr_found;
    logic                    accept, tgt_valid, new_alloc;

    // Match decode, readiness and target voice selection (off is applied before on)
    always_comb begin
        off_hit  = '0;
        on_hit   = '0;
        rt_idx   = '0;
        fr_idx   = '0;
        rt_found = 1'b0;
        fr_found = 1'b0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            off_hit[i] = off_valid && busy_q[i] && (note_q[i] == off_note);
            on_hit[i]  = busy_q[i] && (note_q[i] == on_note);
        end
        surv_hit = on_hit & ~off_hit;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (!rt_found && surv_hit[i]) begin
                rt_idx   = CW'(i);
                rt_found = 1'b1;
            end
            // Only voices free before this edge are candidates; freshly
            // released voices are not reused in the same cycle.
            if (!fr_found && !busy_q[i]) begin
                fr_idx   = CW'(i);
                fr_found = 1'b1;
            end
        end
        on_ready  = !all_off && ((~&busy_q) || (|on_hit));
        accept    = on_valid && on_ready;
        tgt_valid = accept && (rt_found || fr_found);
        new_alloc = !rt_found;
        tgt_idx   = rt_found ? rt_idx : fr_idx;
        tgt_oh    = '0;
        if (tgt_valid) begin
            tgt_oh[tgt_idx] = 1'b1;
        end
        slot_oh         = '0;
        slot_oh[cnt_q]  = 1'b1;
    end

    // Next-state for voice table and registered scan outputs
    always_comb begin
        busy_d  = all_off ? '0 : (busy_q & ~off_hit);
        pend_d  = all_off ? '0 : (pend_q & ~off_hit);
        note_d  = note_q;
        tw_d    = tw_q;
        en_d    = '0;
        clr_d   = '0;
        cnt_d   = cnt_q + CW'(1);
        curr_d  = slot_oh;
        fs_d    = (cnt_q == '0);

        // A voice accepted on its own slot edge defers its clear to the next visit
        if (!(|(tgt_oh & slot_oh))) begin
            if (pend_d[cnt_q]) begin
                clr_d          = slot_oh;
                pend_d[cnt_q]  = 1'b0;
            end else if (busy_d[cnt_q]) begin
                en_d = slot_oh;
            end
        end

        if (tgt_valid) begin
            busy_d[tgt_idx] = 1'b1;
            pend_d[tgt_idx] = 1'b1;
            tw_d[tgt_idx]   = on_tw;
            if (new_alloc) begin
                note_d[tgt_idx] = on_note;
            end
        end

        twout_d = busy_d[cnt_q] ? tw_d[cnt_q] : '0;
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            curr_q  <= '0;
            en_q    <= '0;
            clr_q   <= '0;
            twout_q <= '0;
            fs_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                note_q[i] <= '0;
                tw_q[i]   <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            curr_q  <= curr_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            twout_q <= twout_d;
            fs_q    <= fs_d;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                note_q[i] <= note_d[i];
                tw_q[i]   <= tw_d[i];
            end
        end
    end

    assign acc_en      = en_q;
    assign acc_clr     = clr_q;
    assign curr_note   = curr_q;
    assign tuning_word = twout_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_voice_sched.sv
// Self-checking bench for voice_sched: directed scenarios with literal
// expectations plus randomized traffic against a behavioural voice model.
module tb_voice_sched;

    localparam int N  = 16;
    localparam int NB = 32;
    localparam int NT = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          on_valid;
    logic          on_ready;
    logic [NT-1:0] on_note;
    logic [NB-1:0] on_tw;
    logic          off_valid;
    logic [NT-1:0] off_note;
    logic          all_off;
    logic [N-1:0]  acc_en, acc_clr, curr_note, busy;
    logic [NB-1:0] tuning_word;
    logic          frame_start;

    voice_sched #(.NUM_CHANNELS(N), .NUM_BITS(NB), .NOTE_BITS(NT)) dut (
        .clk(clk), .rst(rst),
        .on_valid(on_valid), .on_ready(on_ready), .on_note(on_note), .on_tw(on_tw),
        .off_valid(off_valid), .off_note(off_note), .all_off(all_off),
        .acc_en(acc_en), .acc_clr(acc_clr), .curr_note(curr_note),
        .tuning_word(tuning_word), .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural voice table
    bit        m_busy [N];
    bit        m_pend [N];
    int        m_note [N];
    bit [31:0] m_tw   [N];
    int        m_slot;
    bit [N-1:0]  e_en, e_clr, e_curr;
    bit [NB-1:0] e_tw;
    bit          e_fs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [N-1:0] m_busy_vec();
        bit [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit m_ready();
        bit any_free = 0, any_match = 0;
        for (int i = 0; i < N; i++) begin
            if (!m_busy[i]) any_free = 1;
            else if (m_note[i] == int'(on_note)) any_match = 1;
        end
        return !all_off && (any_free || any_match);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_pend[i] = 0; m_note[i] = 0; m_tw[i] = 0;
        end
        m_slot = 0; e_en = '0; e_clr = '0; e_curr = '0; e_tw = '0; e_fs = 0;
    endtask

    // One clock edge of the voice rules, using the inputs currently driven
    task automatic m_step();
        bit freed [N];
        bit acc;
        int tgt = -1;
        int k = m_slot;
        acc = on_valid && m_ready();
        for (int i = 0; i < N; i++)
            freed[i] = all_off || (off_valid && m_busy[i] && m_note[i] == int'(off_note));
        if (acc) begin
            for (int i = 0; i < N && tgt < 0; i++)
                if (m_busy[i] && !freed[i] && m_note[i] == int'(on_note)) tgt = i;
            for (int i = 0; i < N && tgt < 0; i++)
                if (!m_busy[i]) tgt = i;
        end
        e_curr = '0; e_curr[k] = 1'b1;
        e_fs   = (k == 0);
        e_en   = '0;
        e_clr  = '0;
        for (int i = 0; i < N; i++)
            if (freed[i]) begin m_busy[i] = 0; m_pend[i] = 0; end
        if (tgt != k) begin
            if (m_pend[k]) begin e_clr[k] = 1'b1; m_pend[k] = 0; end
            else if (m_busy[k]) e_en[k] = 1'b1;
        end
        if (tgt >= 0) begin
            m_busy[tgt] = 1; m_pend[tgt] = 1; m_tw[tgt] = on_tw; m_note[tgt] = int'(on_note);
        end
        e_tw   = m_busy[k] ? m_tw[k] : '0;
        m_slot = (k + 1) % N;
    endtask

    task automatic compare_all();
        chk("curr_note",   curr_note,   e_curr);
        chk("acc_en",      acc_en,      e_en);
        chk("acc_clr",     acc_clr,     e_clr);
        chk("tuning_word", tuning_word, e_tw);
        chk("frame_start", frame_start, e_fs);
        chk("busy",        busy,        m_busy_vec());
        chk("on_ready",    on_ready,    m_ready());
    endtask

    // Called at a falling edge: drive, compare, take the rising edge, return at next falling edge
    task automatic cyc(input bit ov, input int onn, input bit [31:0] tw,
                       input bit fv, input int ofn, input bit ao);
        on_valid  = ov;
        on_note   = NT'(onn);
        on_tw     = tw;
        off_valid = fv;
        off_note  = NT'(ofn);
        all_off   = ao;
        #1 compare_all();
        @(posedge clk);
        if (rst) m_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0; on_valid = 0; on_note = '0; on_tw = '0;
        off_valid = 0; off_note = '0; all_off = 0;
        m_reset();
        @(negedge clk);
        idle(3);
        chk("reset_busy", busy, 16'h0000);
        chk("reset_curr", curr_note, 16'h0000);
        rst = 1'b1;

        // Reset release: first edge presents slot 0
        idle(1);
        chk("first_curr", curr_note, 16'h0001);
        chk("first_fs",   frame_start, 1'b1);

        // Single note-on: clear at next slot 0, then enable with its word
        cyc(1, 60, 32'h0123_4567, 0, 0, 0);
        chk("on60_busy", busy, 16'h0001);
        for (int i = 0; i < 20 && e_curr != 16'h0001; i++) idle(1);
        chk("on60_clr", acc_clr, 16'h0001);
        chk("on60_en0", acc_en,  16'h0000);
        idle(N);
        chk("on60_en",  acc_en,  16'h0001);
        chk("on60_tw",  tuning_word, 32'h0123_4567);

        // Off 60 with on 64 in the same cycle: freed voice not reused
        cyc(1, 64, 32'h0000_0bad, 1, 60, 0);
        chk("swap_busy", busy, 16'h0002);
        idle(2 * N);

        // all_off with a simultaneous note-on
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 40 + i, $urandom, 0, 0, 0);
        chk("five_busy", busy, 16'h001F);
        on_note = NT'(70); on_valid = 1; all_off = 1;
        #1 chk("alloff_ready", on_ready, 1'b0);
        cyc(1, 70, 32'h7777_7777, 0, 0, 1);
        chk("alloff_busy", busy, 16'h0000);
        idle(N + 2);
        chk("alloff_en", acc_en, 16'h0000);

        // Fill all sixteen voices, then try a seventeenth
        for (int i = 0; i < N; i++) cyc(1, 10 + i, 32'h1000 + i, 0, 0, 0);
        chk("full_busy", busy, 16'hFFFF);
        on_note = NT'(99); on_valid = 1;
        #1 chk("full_ready_new", on_ready, 1'b0);
        cyc(1, 99, 32'hDEAD_BEEF, 0, 0, 0);
        on_note = NT'(15);
        #1 chk("full_ready_match", on_ready, 1'b1);
        cyc(1, 15, 32'hCAFE_0015, 0, 0, 0);
        chk("retrig_busy", busy, 16'hFFFF);
        idle(2 * N + 3);

        // Build busy = 0x00F0 then reset asynchronously mid-frame
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(1, 30 + i, $urandom, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 30 + i, 0);
        chk("f0_busy", busy, 16'h00F0);
        idle(5);
        #3 rst = 1'b0;
        #1 m_reset();
        chk("arst_busy", busy, 16'h0000);
        chk("arst_curr", curr_note, 16'h0000);
        chk("arst_tw",   tuning_word, 32'h0);
        chk("arst_fs",   frame_start, 1'b0);
        @(negedge clk);
        idle(1);
        rst = 1'b1;
        idle(1);
        chk("rel_curr", curr_note, 16'h0001);
        chk("rel_busy", busy, 16'h0000);

        // Randomized traffic over a small note range to exercise matches and fills
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 50), $urandom_range(0, 23), $urandom,
                ($urandom_range(0, 99) < 25), $urandom_range(0, 23),
                ($urandom_range(0, 199) == 0));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
